// File: rtl/sap_pkg.sv
// Shared SAP-1 constants and the program-loader state encoding.
// Imported by the loader and anything else that touches the 16x8 program RAM.
package sap_pkg;

  localparam int SAP_ADDR_W = 4;
  localparam int SAP_DATA_W = 8;
  localparam int SAP_DEPTH  = 1 << SAP_ADDR_W;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_LOAD  = 3'd1,
    LD_CHECK = 3'd2,
    LD_DONE  = 3'd3,
    LD_FAIL  = 3'd4
  } loader_state_t;

endpackage

// File: rtl/sap_ram_loader.sv
// SAP-1 program RAM writer: streams 16 bytes into RAM 0..15, then releases the CPU.
// Optional trailing checksum byte enabled by `define SAP_LOADER_CHECKSUM_EN.
module sap_ram_loader
  import sap_pkg::*;
#(
  parameter int ADDR_W = SAP_ADDR_W,
  parameter int DATA_W = SAP_DATA_W
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_run,
  output logic [ADDR_W:0]   count
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST  = (ADDR_W + 1)'(DEPTH - 1);

  loader_state_t     state;
  logic [ADDR_W-1:0] ptr;
  logic              xfer;

  // Ready decodes straight from state so a byte can land the very cycle LOAD is entered.
  assign in_ready = (state == LD_LOAD) || (state == LD_CHECK);
  assign xfer     = in_valid & in_ready;

`ifdef SAP_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] sum_fin;

  assign sum_fin = sum + in_data;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state     <= LD_IDLE;
      ptr       <= '0;
      count     <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_run   <= 1'b0;
`ifdef SAP_LOADER_CHECKSUM_EN
      err       <= 1'b0;
      sum       <= '0;
`endif
    end else begin
      ram_we <= 1'b0;
      case (state)
        LD_IDLE, LD_DONE, LD_FAIL: begin
          // start has priority; in_ready is low here so a coincident byte is dropped
          if (start) begin
            state   <= LD_LOAD;
            ptr     <= '0;
            count   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            cpu_run <= 1'b0;
`ifdef SAP_LOADER_CHECKSUM_EN
            err     <= 1'b0;
            sum     <= '0;
`endif
          end
        end
        LD_LOAD: begin
          if (xfer) begin
            ram_we    <= 1'b1;
            ram_addr  <= ptr;
            ram_wdata <= in_data;
            ptr       <= ptr + 1'b1;
            count     <= count + 1'b1;
`ifdef SAP_LOADER_CHECKSUM_EN
            sum       <= sum_fin;
            if (count == LAST) state <= LD_CHECK;
`else
            if (count == LAST) begin
              state   <= LD_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              cpu_run <= 1'b1;
            end
`endif
          end
        end
`ifdef SAP_LOADER_CHECKSUM_EN
        LD_CHECK: begin
          // trailing byte is compared only, never written to RAM
          if (xfer) begin
            busy <= 1'b0;
            if (sum_fin == '0) begin
              state   <= LD_DONE;
              done    <= 1'b1;
              cpu_run <= 1'b1;
            end else begin
              state <= LD_FAIL;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_ram_loader.sv
// Self-checking bench for sap_ram_loader: table-driven loads, scoreboarded RAM writes,
// hand sequences for reset-mid-load, DONE restart and (with the macro) checksum outcomes.
module tb_sap_ram_loader;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, ram_we, busy, done, err, cpu_run;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [4:0] count;

  sap_ram_loader dut (
    .CLK(CLK), .CLR(CLR), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .err(err), .cpu_run(cpu_run), .count(count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    int         gap;
    logic [7:0] base;
    logic [7:0] step;
    int         exp_done;
    int         exp_run;
    int         exp_count;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;
  wr_t        sb[$];
  wr_t        e;
  logic [3:0] exp_ptr = 4'd0;
  logic [7:0] ram [16];
  logic [7:0] exp_img [16];
  vec_t       tbl [4];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // RAM model plus write scoreboard
  always @(posedge CLK) if (ram_we) ram[ram_addr] <= ram_wdata;

  always @(negedge CLK) begin
    if (ram_we) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we: got addr %0h data %0h expected no write", ram_addr, ram_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(ram_addr), 32'(e.addr));
        chk("wr_data", 32'(ram_wdata), 32'(e.data));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    exp_ptr = 4'd0;
  endtask

  task automatic send(input logic [7:0] d, input bit wr);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge CLK);
    while (!in_ready && n < 20) begin @(negedge CLK); n++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end else if (wr) begin
      sb.push_back('{exp_ptr, d});
      exp_ptr++;
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  // Sends bytes [from..15] of base+i*step, then the checksum byte (macro builds).
  task automatic load_bytes(input logic [7:0] base, input logic [7:0] step, input int gap,
                            input int from, input logic [7:0] cks_adj);
    logic [7:0] d, s;
    s = 8'h00;
    for (int i = 0; i < 16; i++) begin
      d = base + 8'(i) * step;
      exp_img[i] = d;
      s = s + d;
    end
    for (int i = from; i < 16; i++) begin
      send(exp_img[i], 1'b1);
      if (i != 15) idle(gap);
    end
`ifdef SAP_LOADER_CHECKSUM_EN
    chk("check_busy", 32'(busy), 1);
    chk("check_done", 32'(done), 0);
    chk("check_ready", 32'(in_ready), 1);
    send(8'(8'h00 - s) + cks_adj, 1'b0);
`else
    chk("done_next_cycle", 32'(done), 1);
    chk("run_next_cycle", 32'(cpu_run), 1);
    chk("ready_done", 32'(in_ready), 0);
    s = cks_adj;
`endif
  endtask

  task automatic check_image(input string nm);
    for (int i = 0; i < 16; i++) chk(nm, 32'(ram[i]), 32'(exp_img[i]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int w0;
    tbl[0] = '{0, 8'h01, 8'h01, 1, 1, 16};
    tbl[1] = '{1, 8'h01, 8'h01, 1, 1, 16};
    tbl[2] = '{2, 8'hA0, 8'h03, 1, 1, 16};
    tbl[3] = '{0, 8'hFF, 8'hFF, 1, 1, 16};

    // reset state
    #12;
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_run", 32'(cpu_run), 0);
    chk("rst_addr_data", 32'({ram_addr, ram_wdata}), 0);
    chk("rst_count", 32'(count), 0);
    @(posedge CLK); #1;
    CLR = 1'b1;

    // bytes offered before start are ignored
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) begin @(negedge CLK); chk("idle_ready", 32'(in_ready), 0); end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("idle_count", 32'(count), 0);
    chk("idle_busy", 32'(busy), 0);

    for (int v = 0; v < 4; v++) begin
      w0 = wr_cnt;
      pulse_start();
      chk("load_busy", 32'(busy), 1);
      chk("load_count0", 32'(count), 0);
      load_bytes(tbl[v].base, tbl[v].step, tbl[v].gap, 0, 8'h00);
      idle(2);
      chk("sb_drained", 32'(sb.size()), 0);
      chk("wr_cnt", 32'(wr_cnt - w0), 16);
      chk("tbl_done", 32'(done), 32'(tbl[v].exp_done));
      chk("tbl_run", 32'(cpu_run), 32'(tbl[v].exp_run));
      chk("tbl_count", 32'(count), 32'(tbl[v].exp_count));
      chk("tbl_busy", 32'(busy), 0);
      chk("tbl_err", 32'(err), 0);
      check_image("tbl_ram");
    end

    // extra bytes in DONE are ignored
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) begin @(negedge CLK); chk("done_ready", 32'(in_ready), 0); end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    idle(1);
    chk("done_count", 32'(count), 16);
    check_image("done_ram");

    // start with a coincident byte in DONE: start wins, byte dropped
    in_valid = 1'b1;
    in_data  = 8'h55;
    start    = 1'b1;
    @(negedge CLK);
    chk("start_ready", 32'(in_ready), 0);
    @(posedge CLK); #1;
    start = 1'b0;
    in_valid = 1'b0;
    exp_ptr = 4'd0;
    chk("restart_run", 32'(cpu_run), 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_done", 32'(done), 0);
    chk("restart_count", 32'(count), 0);
    for (int i = 0; i < 7; i++) send(8'h66 + 8'(i), 1'b1);
    chk("count7", 32'(count), 7);

    // async reset mid-load
    #1;
    CLR = 1'b0;
    #1;
    chk("clr_we", 32'(ram_we), 0);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_count", 32'(count), 0);
    chk("clr_addr", 32'(ram_addr), 0);
    chk("clr_ready", 32'(in_ready), 0);
    sb.delete();
    @(posedge CLK); #1;
    CLR = 1'b1;
    idle(1);
    pulse_start();
    chk("reload_count", 32'(count), 0);
    send(8'h77, 1'b1);
    chk("reload_count1", 32'(count), 1);
    load_bytes(8'h77, 8'h01, 0, 1, 8'h00);
    idle(2);
    chk("reload_done", 32'(done), 1);
    check_image("reload_ram");

`ifdef SAP_LOADER_CHECKSUM_EN
    pulse_start();
    load_bytes(8'h01, 8'h00, 0, 0, 8'h00);
    chk("cks_ok_done", 32'(done), 1);
    chk("cks_ok_err", 32'(err), 0);
    chk("cks_ok_run", 32'(cpu_run), 1);
    pulse_start();
    load_bytes(8'h01, 8'h00, 0, 0, 8'h01);
    chk("cks_bad_err", 32'(err), 1);
    chk("cks_bad_run", 32'(cpu_run), 0);
    chk("cks_bad_done", 32'(done), 0);
    chk("cks_bad_ready", 32'(in_ready), 0);
    pulse_start();
    chk("cks_clr_err", 32'(err), 0);
    chk("cks_clr_busy", 32'(busy), 1);
    load_bytes(8'h20, 8'h01, 0, 0, 8'h00);
    idle(2);
    chk("cks_final_done", 32'(done), 1);
    check_image("cks_ram");
`endif

    chk("final_sb", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
